// File: rtl/bsg_arb_rr_one_hot_hold.sv
// rtl/bsg_arb_rr_one_hot_hold.sv - registered round-robin arbiter whose one-hot grant is held until yumi
module bsg_arb_rr_one_hot_hold #(
  parameter int els_p = 4,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [els_p-1:0]     v_i,
  output logic [els_p-1:0]     yumi_o,
  output logic [els_p-1:0]     sel_one_hot_o,
  output logic [lg_els_lp-1:0] sel_id_o,
  output logic                 v_o,
  input  logic                 yumi_i
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  logic [els_p-1:0]     r_grant;
  logic [lg_els_lp-1:0] r_last;

  state_e               w_state;
  logic [lg_els_lp-1:0] w_sel_id;
  logic [lg_els_lp-1:0] w_base;
  logic [els_p-1:0]     w_mask;
  logic [els_p-1:0]     w_pick;
  logic                 w_found;
  logic [lg_els_lp-1:0] w_idx;
  int                   w_sum;

  assign w_state = (|r_grant) ? HOLD : IDLE;

  always_comb begin
    w_sel_id = '0;
    for (int i = 0; i < els_p; i++) begin
      if (r_grant[i]) w_sel_id = w_sel_id | lg_els_lp'(i);
    end
  end

  // On a consume the pointer advances past the current winner in the same cycle,
  // and masking the held grant keeps the consumed requester out of this pick.
  assign w_base = (w_state == HOLD) ? w_sel_id : r_last;
  assign w_mask = v_i & ~r_grant;

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 1; k <= els_p; k++) begin
      w_sum = int'(w_base) + k;
      if (w_sum >= els_p) w_sum = w_sum - els_p;
      w_idx = w_sum[lg_els_lp-1:0];
      if (!w_found && w_mask[w_idx]) begin
        w_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_grant <= '0;
      r_last  <= lg_els_lp'(els_p - 1);
    end else begin
      case (w_state)
        IDLE: r_grant <= w_pick;
        HOLD: begin
          if (yumi_i) begin
            r_grant <= w_pick;
            r_last  <= w_sel_id;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign sel_one_hot_o = r_grant;
  assign sel_id_o      = w_sel_id;
  assign v_o           = (w_state == HOLD);
  assign yumi_o        = (reset_n_i && yumi_i) ? r_grant : '0;

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(r_grant));
      assert ((r_grant == '0) ? (w_sel_id == '0) : r_grant[w_sel_id]);
      assert (!(yumi_i && !v_o));
      assert ((r_grant & ~v_i) == '0);
    end
  end

endmodule

// File: tb/tb_bsg_arb_rr_one_hot_hold.sv
// tb/tb_bsg_arb_rr_one_hot_hold.sv - directed self-checking bench for bsg_arb_rr_one_hot_hold
module tb_bsg_arb_rr_one_hot_hold;

  logic       clk;
  logic       reset_n_i;
  logic [3:0] v_i;
  logic [3:0] yumi_o;
  logic [3:0] sel_one_hot_o;
  logic [1:0] sel_id_o;
  logic       v_o;
  logic       yumi_i;

  int n_assert;
  int n_fail;

  bsg_arb_rr_one_hot_hold #(.els_p(4)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .v_i           (v_i),
    .yumi_o        (yumi_o),
    .sel_one_hot_o (sel_one_hot_o),
    .sel_id_o      (sel_id_o),
    .v_o           (v_o),
    .yumi_i        (yumi_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic vec(input string tag, input logic rn, input logic [3:0] v, input logic y,
                     input logic [3:0] es, input logic [1:0] eid, input logic ev,
                     input logic [3:0] ey);
    @(negedge clk);
    reset_n_i = rn;
    v_i       = v;
    yumi_i    = y;
    #1;
    chk({tag, ".sel"},  32'(sel_one_hot_o), 32'(es));
    chk({tag, ".id"},   32'(sel_id_o),      32'(eid));
    chk({tag, ".v"},    32'(v_o),           32'(ev));
    chk({tag, ".yumi"}, 32'(yumi_o),        32'(ey));
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    reset_n_i = 1'b0;
    v_i       = 4'b1111;
    yumi_i    = 1'b0;
    @(posedge clk);

    vec("rst1", 1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("rst2", 1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("rst3", 1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("rel",  1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);

    vec("fc0",  1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001);
    vec("fc1",  1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010);
    vec("fc2",  1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100);
    vec("fc3",  1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000);
    vec("fc4",  1'b1, 4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001);

    vec("bp1",  1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("bp2",  1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("bp3",  1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("bp4",  1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("bp5",  1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("bp6",  1'b1, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("bp7",  1'b1, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100);
    vec("bp8",  1'b1, 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001);

    vec("sw0",  1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000);
    vec("sw1",  1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("sw2",  1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("sw3",  1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000);
    vec("sw4",  1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);

    vec("ex0",  1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("ex1",  1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010);
    vec("ex2",  1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("ex3",  1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010);

    vec("rm0",  1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("rm1",  1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("rm2",  1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0000);
    vec("rm3",  1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
    vec("rm4",  1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
